// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC and buffers imem words in a
// prefetch FIFO for decode. Optional perf counters under `ifdef FETCH_PERF_EN.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_end,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_fetch_cnt
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = 33'(MEM_WORDS) * 33'd4;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [31:0] r_fetch_pc;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_misalign;
  logic [31:0] r_pc_mem    [DEPTH];
  logic [31:0] r_instr_mem [DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_fetch_end;
  logic [31:0] w_redirect_aligned;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  // 33-bit compare so a MEM_WORDS reaching 4 GiB never wraps the limit.
  assign w_fetch_end = ({1'b0, r_fetch_pc} >= END_ADDR);
  assign w_pop       = !w_empty && out_ready;
  assign w_push      = !w_fetch_end && (!w_full || w_pop);

  assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign imem_addr    = r_fetch_pc;
  assign out_valid    = !w_empty;
  assign out_pc       = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr[AW-1:0]];
  assign out_instr    = w_empty ? 32'h0 : r_instr_mem[r_rd_ptr[AW-1:0]];
  assign fetch_end    = w_fetch_end;
  assign misalign_err = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_aligned;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push && !redirect_valid) begin
      r_pc_mem[r_wr_ptr[AW-1:0]]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr[AW-1:0]] <= imem_instr;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fetch_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_push && !redirect_valid && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/redirect traffic against a queue-based model of the fetch stream.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] END_ADDR  = MEM_WORDS * 4;
  localparam int          IW        = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_end;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fetch_cnt;
`endif

  logic [31:0] mem [MEM_WORDS];
  assign imem_instr = (imem_addr < END_ADDR) ? mem[imem_addr[IW+1:2]] : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_end(fetch_end), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the FIFO is just the list of PCs decode has yet to receive.
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  bit          m_mis;
  logic [31:0] m_stall;
  logic [31:0] m_fetch;

  function automatic logic [98:0] exp_vec();
    logic [31:0] hp;
    logic [31:0] hi;
    logic [31:0] idx;
    hp = 32'h0;
    hi = 32'h0;
    if (mq.size() > 0) begin
      hp  = mq[0];
      idx = hp >> 2;
      hi  = mem[idx[IW-1:0]];
    end
    return {mq.size() > 0, hp, hi, m_pc, m_pc >= END_ADDR, m_mis};
  endfunction

  function automatic logic [98:0] dut_vec();
    return {out_valid, out_pc, out_instr, imem_addr, fetch_end, misalign_err};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_mis   = 1'b0;
    m_stall = 32'h0;
    m_fetch = 32'h0;
  endtask

  // Advance model and DUT one clock with the inputs currently driven.
  task automatic step();
    bit pop;
    bit push;
    pop  = (mq.size() > 0) && out_ready;
    push = (m_pc < END_ADDR) && ((mq.size() < DEPTH) || pop);
    if ((mq.size() > 0) && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (redirect_valid) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    hold_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
    n_checks++;
    if ({out_valid, out_pc, out_instr} !== 65'h0) $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_pc, out_instr});
    else n_pass++;
    n_checks++;
    if (imem_addr !== RESET_PC || fetch_end !== 1'b0 || misalign_err !== 1'b0)
      $display("FAIL reset_pc: got addr=%h end=%b mis=%b expected addr=%h end=0 mis=0", imem_addr, fetch_end, misalign_err, RESET_PC);
    else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'h0 || perf_fetch_cnt !== 32'h0)
      $display("FAIL reset_perf: got stall=%0d fetch=%0d expected 0 0", perf_stall_cnt, perf_fetch_cnt);
    else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] w [4];
    w[0] = 32'h00500093; w[1] = 32'h00a00113; w[2] = 32'h00314193; w[3] = 32'h00516213;
    for (int i = 0; i < 4; i++) mem[i] = w[i];
    release_reset();
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stream_pre_valid: got %b expected 0", out_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== w[i])
        $display("FAIL stream_%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", i, out_valid, out_pc, out_instr, 32'(i * 4), w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    release_reset();
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1)
      $display("FAIL bp_hold: got addr=%h pc=%h v=%b expected addr=8 pc=0 v=1", imem_addr, out_pc, out_valid);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL bp_vec: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4))
        $display("FAIL bp_drain_%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_redirect();
    release_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    step();
    n_checks++;
    if (out_pc !== 32'h10 || imem_addr !== 32'h18)
      $display("FAIL redir_setup: got pc=%h addr=%h expected pc=10 addr=18", out_pc, imem_addr);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h60;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h60)
      $display("FAIL redir_n1: got v=%b addr=%h expected v=0 addr=60", out_valid, imem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h60 + 32'(i * 4))
        $display("FAIL redir_n%0d: got v=%b pc=%h expected v=1 pc=%h", i + 2, out_valid, out_pc, 32'h60 + 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    release_reset();
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h62;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (misalign_err !== 1'b1) $display("FAIL misalign_set: got %b expected 1", misalign_err);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h60)
      $display("FAIL misalign_target: got v=%b pc=%h expected v=1 pc=60", out_valid, out_pc);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if (misalign_err !== 1'b1 || out_pc !== 32'h20)
      $display("FAIL misalign_sticky: got mis=%b pc=%h expected mis=1 pc=20", misalign_err, out_pc);
    else n_pass++;
  endtask

  task automatic test_end_of_mem();
    release_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hF0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL end_walk_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (fetch_end !== 1'b1 || imem_addr !== 32'h100 || out_pc !== 32'hFC)
      $display("FAIL end_reached: got end=%b addr=%h pc=%h expected end=1 addr=100 pc=fc", fetch_end, imem_addr, out_pc);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100 || fetch_end !== 1'b1)
      $display("FAIL end_drained: got v=%b addr=%h end=%b expected v=0 addr=100 end=1", out_valid, imem_addr, fetch_end);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_end !== 1'b0 || imem_addr !== 32'h0)
      $display("FAIL end_rearm: got end=%b addr=%h expected end=0 addr=0", fetch_end, imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0)
      $display("FAIL end_resume: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    release_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL mid_reset: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    release_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 32'($urandom_range(0, 72)) * 32'd4 + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        if (errs < 5) $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
        errs++;
      end else n_pass++;
`ifdef FETCH_PERF_EN
      n_checks++;
      if (perf_stall_cnt !== m_stall || perf_fetch_cnt !== m_fetch) begin
        if (errs < 5) $display("FAIL random_perf_%0d: got %0d/%0d expected %0d/%0d", i, perf_stall_cnt, perf_fetch_cnt, m_stall, m_fetch);
        errs++;
      end else n_pass++;
`endif
    end
    redirect_valid = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int accepted;
    int iter;
    accepted = 0;
    iter     = 0;
    release_reset();
    out_ready = 1'b1;
    step();
    while (accepted < 10 && iter < 100) begin
      out_ready = !(iter == 2 || iter == 3 || iter == 6);
      if (out_valid && out_ready) accepted++;
      step();
      iter++;
    end
    n_checks++;
    if (accepted != 10) $display("FAIL perf_timeout: got %0d accepted expected 10", accepted);
    else n_pass++;
    n_checks++;
    if (perf_stall_cnt !== 32'd3 || perf_fetch_cnt < 32'd10)
      $display("FAIL perf_counts: got stall=%0d fetch=%0d expected stall=3 fetch>=10", perf_stall_cnt, perf_fetch_cnt);
    else n_pass++;
    n_checks++;
    if (perf_fetch_cnt !== m_fetch) $display("FAIL perf_fetch_exact: got %0d expected %0d", perf_fetch_cnt, m_fetch);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (perf_stall_cnt !== 32'h0 || perf_fetch_cnt !== 32'h0)
      $display("FAIL perf_reset: got stall=%0d fetch=%0d expected 0 0", perf_stall_cnt, perf_fetch_cnt);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_end_of_mem();
    test_mid_reset();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequences the combinational instruction memory: owns the fetch PC, drives the word address each cycle, and buffers fetched words in a small prefetch FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute by flushing the buffer and restarting fetch at the new PC.
- Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.
- MEM_WORDS, 64, instruction memory size in 32-bit words; fetch stops at byte address MEM_WORDS*4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  PC of the instruction at FIFO head.
- redirect_valid  input  1  execute requests a PC change (taken branch, JAL, JALR).
- redirect_pc  input  32  target byte address.
- fetch_end  output  1  fetch_pc has reached MEM_WORDS*4; no further pushes.
- misalign_err  output  1  sticky; set when a redirect target has [1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; out_valid = 0; misalign_err = 0; fetch_end = (RESET_PC >= MEM_WORDS*4).
  - out_instr and out_pc read 0 while the FIFO is empty.
- imem_addr = fetch_pc, driven combinationally from the register.
- pop = out_valid & out_ready. push = !fetch_end & (!full | pop).
- On push, store {fetch_pc, imem_instr} at the tail and set fetch_pc = fetch_pc + 4, 32-bit wrap.
- Push and pop in the same cycle when full is legal; occupancy stays unchanged.
- out_valid = !empty. out_instr/out_pc come straight from the head entry (registered storage); no combinational path from imem_instr to the outputs.
- Latency:
  - After reset release, the first clk edge pushes RESET_PC's word.
  - out_valid rises 1 cycle after reset release.
  - Throughput is 1 instruction/cycle while out_ready = 1.
- Redirect has the highest priority. When redirect_valid is high on an edge:
  - the FIFO is flushed (the same-cycle pop and push are discarded);
  - fetch_pc = {redirect_pc[31:2], 2'b00};
  - fetch_end is recomputed.
- After a redirect:
  - the cycle after the redirect edge, out_valid = 0 and the target word is pushed;
  - out_valid = 1 with out_pc = target two cycles after redirect_valid was sampled.
- Misalignment: if redirect_valid and redirect_pc[1:0] != 0, misalign_err is set and stays set until reset; the redirect still proceeds with the aligned address.
- End of memory: fetch_end is high while fetch_pc >= MEM_WORDS*4. Pushes stop, and already-buffered entries still drain normally.
- Redirect while fetch_end is high re-arms fetch if the target is in range.
- out_ready while empty has no effect. Full with no pop holds fetch_pc, so the upstream address is stable.
- Reset asserted mid-stream clears everything immediately. Entries in flight are lost.
- Pointers are log2(DEPTH)+1 bits, with the wrap bit used for full/empty discrimination.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, the block adds output perf_stall_cnt [31:0] and output perf_fetch_cnt [31:0]:
  - perf_stall_cnt increments on every cycle with out_valid & !out_ready;
  - perf_fetch_cnt increments on every push;
  - both are cleared by rst_n only, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset release, out_ready=1 constantly, memory words 0..3 = 32'h00500093, 32'h00a00113, 32'h00314193, 32'h00516213 -> out_valid rises 1 cycle after release; out_pc 0,4,8,C on consecutive cycles with matching out_instr.
- out_ready=0 for 5 cycles after first valid, DEPTH=2 -> FIFO fills with PCs 0 and 4, imem_addr holds 8, out_pc stays 0; on out_ready=1, PCs 0,4,8 stream without gaps or duplicates.
- redirect_valid=1, redirect_pc=32'h60, sampled at cycle N while FIFO holds PCs 0x10 and 0x14 -> out_valid=0 at N+1; out_valid=1 with out_pc=0x60 at N+2; 0x10 and 0x14 are never emitted.
- redirect_pc=32'h62 -> misalign_err=1 and stays set; next out_pc=0x60; a later aligned redirect does not clear it.
- MEM_WORDS=64, fetch to 0xFC -> after pushing 0xFC, fetch_end=1 and imem_addr holds 0x100; buffer drains; then redirect to 0x0 clears fetch_end and resumes at out_pc=0.
- With FETCH_PERF_EN defined: 10 streamed instructions with 3 back-pressure cycles on a valid head -> perf_fetch_cnt >= 10 and perf_stall_cnt == 3; rst_n pulse -> both read 0.
